// File: rtl/rng_reader_pkg.sv
// rng_reader_pkg: shared types and constants for the random byte reader
package rng_reader_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
endpackage

// File: rtl/rng_word_fifo.sv
// rng_word_fifo: synchronous word FIFO with level count and async reset
module rng_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/rng_byte_reader.sv
// rng_byte_reader: buffers random words and serves them MSB-byte-first with a repetition health test
module rng_byte_reader
  import rng_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REP_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      word_in,
  input  logic                   word_valid,
  input  logic                   clear,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   rep_fail
);
  localparam int CW = $clog2(REP_LIMIT + 1);
  localparam int IW = $clog2(BYTES_PER_WORD);
  state_t            state;
  logic [WORD_W-1:0] sreg, prev, fifo_dout;
  logic [IW-1:0]     idx, nidx;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              have_prev, full, empty, push, pop, drop, can_pop;
  assign can_pop = !empty && !rep_fail;
  assign pop     = state == IDLE ? can_pop : byte_ack && idx == '0 && can_pop;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push    = word_valid && (!full || pop);
  assign drop    = word_valid && full && !pop;
  assign cnt_nxt = (have_prev && word_in == prev) ? (cnt == CW'(REP_LIMIT) ? cnt : cnt + CW'(1)) : CW'(1);
  assign nidx    = idx - IW'(1);
  rng_word_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(word_in),
    .dout(fifo_dout), .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt       <= CW'(1);
      prev      <= '0;
      have_prev <= 1'b0;
      overflow  <= 1'b0;
      rep_fail  <= 1'b0;
    end else begin
      if (push) begin
        prev      <= word_in;
        have_prev <= 1'b1;
      end
      cnt      <= clear ? CW'(1) : push ? cnt_nxt : cnt;
      overflow <= !clear && (overflow || drop);
      rep_fail <= !clear && (rep_fail || (push && cnt_nxt == CW'(REP_LIMIT)));
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      idx        <= IW'(BYTES_PER_WORD - 1);
      byte_out   <= '0;
      byte_valid <= 1'b0;
    end else if (pop) begin
      state      <= SEND;
      sreg       <= fifo_dout;
      idx        <= IW'(BYTES_PER_WORD - 1);
      byte_out   <= fifo_dout[WORD_W-1 -: 8];
      byte_valid <= 1'b1;
    end else if (state == SEND && byte_ack) begin
      if (idx != '0) begin
        idx      <= nidx;
        byte_out <= sreg[{nidx, 3'b000} +: 8];
      end else begin
        state      <= IDLE;
        byte_valid <= 1'b0;
      end
    end
endmodule

// File: doc/rng_byte_reader.md
# rng_byte_reader

Consumer end of the 32-bit random-word interface: accepts each fresh word announced by a one-cycle `ready` pulse, buffers it in a small word FIFO, and serves it MSB-byte-first over an 8-bit valid/ack byte port suited to the TinyTapeout output pins. It also runs a repetition-count health test on incoming words. Sticky `overflow` and `rep_fail` flags are visible to the host.

## Interface
- `DEPTH`, 4 — FIFO depth in 32-bit words; power of two, ≥2.
- `REP_LIMIT`, 3 — number of consecutive identical accepted words that trips `rep_fail`; ≥2.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `word_in`  in  32  random word; sampled only when `word_valid`=1.
- `word_valid`  in  1  one-cycle pulse marking a fresh word (driven by the generator's `ready`).
- `clear`  in  1  synchronous; clears `overflow`, `rep_fail` and the repetition counter; FIFO contents kept.
- `byte_out`  out  8  current output byte.
- `byte_valid`  out  1  `byte_out` holds a valid byte.
- `byte_ack`  in  1  consumer accepts `byte_out` on an edge where `byte_valid`=1.
- `level`  out  $clog2(DEPTH)+1  words currently in FIFO (excludes word being sent).
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `rep_fail`  out  1  sticky: repetition test failed.

## Operation
- Reset values: `byte_out`=0, `byte_valid`=0, `level`=0, `overflow`=0, `rep_fail`=0; FSM in IDLE; byte index 3; rep counter 1; previous word 0 with a "no previous" flag set.
- Write side: on `word_valid`, if FIFO not full → push. If full and no pop on the same edge → drop, set `overflow`. Full with simultaneous pop → push accepted, no overflow.
- Repetition test, on every accepted word: if "previous" valid and `word_in`==previous → counter+1, else counter=1; previous←`word_in`. When counter reaches `REP_LIMIT`, set `rep_fail`. Dropped words do not update the test.
- FSM states:
  - IDLE: `byte_valid`=0. If `level`>0 and `rep_fail`=0 → pop word into shift register, index=3, go SEND.
  - SEND: `byte_valid`=1, `byte_out`=word[8*idx+7 : 8*idx]. On `byte_ack`: if idx>0 → idx−1; if idx=0 and `level`>0 and `rep_fail`=0 → pop next word, idx=3, stay SEND; otherwise → IDLE.
- `rep_fail`=1 gates output: no new word is popped. The word currently in SEND finishes normally. Buffered words are held until `clear`.
- `byte_ack` while `byte_valid`=0 is ignored.
- `clear` and a failing write on the same edge: clear wins, counter restarts at 1 with previous←`word_in`.
- `byte_out` holds its value while `byte_valid`=0; no X.

## Timing
- `word_valid` at edge N into an empty FIFO in IDLE: `level`=1 after edge N; pop at edge N+1; `byte_valid`=1 after edge N+1. Latency is 2 clocks; there is no bypass path.
- Steady state with a non-empty FIFO: one byte per clock when `byte_ack` is held high. There is no bubble between words.
- A word takes 4 acknowledged bytes; the FSM returns to IDLE one edge after the last ack when the FIFO is empty.
- `rst` mid-transfer: all outputs return to reset values immediately (asynchronously); FIFO contents are discarded.
- `level` counts are modular only within DEPTH+1 states; pointers wrap at DEPTH.

## Structure
- Package `rng_reader_pkg`: FSM state enum (IDLE, SEND), `BYTES_PER_WORD`=4, `WORD_W`=32.
- Sub-module `rng_word_fifo`: parameterized synchronous FIFO with push/pop, full/empty, level, async reset. It has no drop or flag logic; that stays in the top.

## Test plan
- Single word 0xDEADBEEF, `byte_ack` tied 1 → bytes DE, AD, BE, EF on 4 consecutive cycles. `byte_valid` rises 2 clocks after `word_valid`, then falls.
- Push 0x01020304 and 0x05060708 back-to-back, `byte_ack`=1 → 8 bytes 01…08 with no gap. `level` peaks at 1 or 2 and ends at 0.
- With `byte_ack`=0, push 6 distinct words (DEPTH=4) → first word sits in SEND, `level`=4, one word dropped, `overflow`=1. After `clear`, `overflow`=0 and `level` is still 4.
- Push 0xAAAAAAAA three times (REP_LIMIT=3) → `rep_fail`=1 on the third accepted word. The in-flight word completes, no further pops occur, `level` is held. After `clear`, output resumes.
- Assert `rst` while SEND is at idx=1 → `byte_valid`=0 and `level`=0 immediately. The next word after `rst` is released is output from byte 3.
- `byte_ack` pulses irregularly, including while `byte_valid`=0 → the byte sequence is unchanged, no bytes are skipped, and no spurious advance occurs.
